fpdp_mul_arbiter: RTL and testbench
===================================

FPDP_MUL_ARBITER -- requirements
Module: fpdp_mul_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; fixed at 4, matching the 4-bit ready/done tag width of fpdp_multiplication.
REQ-002 Parameter TIMEOUT, default 255: maximum wait cycles for mul_done before abort; range 1..255.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rset  input  1  synchronous active-high reset.
REQ-006 req  input  4  per-requester request level, held until matching ack.
REQ-007 req_a  input  256  four 64-bit multipliers; requester i occupies bits [64i+63:64i].
REQ-008 req_b  input  256  four 64-bit multiplicands, same packing as req_a.
REQ-009 ack  output  4  one-hot, one-cycle pulse: result valid for that requester.
REQ-010 result  output  64  IEEE-754 double product; valid while ack is nonzero.
REQ-011 err  output  1  qualifies ack: timeout abort.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 mul_multiplier / mul_multiplicand  output  64 each  operands to fpdp_multiplication.
REQ-014 mul_ready  output  4  one-hot start tag; nonzero for exactly one cycle per job.
REQ-015 mul_rset  output  1  reset to the multiplier.
REQ-016 mul_done  input  4  tag echoed by the multiplier when the product is valid.
REQ-017 mul_product  input  64  multiplier result.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: if req != 0, grant the first set bit at or after the round-robin pointer, wrapping 3->0.
- Latch the grant index and that requester's operands.
- Go to ISSUE.
REQ-020 ISSUE (1 cycle): drive the latched operands and mul_ready = one-hot(grant), clear the timeout counter, go to WAIT.
REQ-021 WAIT: mul_ready = 0 and operands held stable; the counter increments each cycle.
REQ-022 WAIT exit on mul_done == one-hot(grant): register mul_product into result, go to RESP.
REQ-023 WAIT exit when the counter reaches TIMEOUT:
- result = 64'h7FF8000000000000 (qNaN), err = 1, mul_rset pulsed for 1 cycle, go to RESP.
REQ-024 RESP (1 cycle): ack = one-hot(grant); set pointer = grant+1 mod 4; go to IDLE.
REQ-025 mul_done values not equal to one-hot(grant), or arriving outside WAIT, SHALL be ignored.
REQ-026 Latency from req seen in IDLE to ack SHALL be 3 + L cycles, where L is multiplier latency in cycles (mul_ready to mul_done).
REQ-027 A requester whose req drops before ack SHALL still receive its ack; the job is not cancelled.
REQ-028 Simultaneous requests SHALL be served one at a time in round-robin order; no requester waits more than 3 other jobs.
REQ-029 A new grant SHALL NOT be issued in the RESP cycle; the earliest re-grant is the following IDLE cycle.
REQ-030 The block SHALL perform no arithmetic on the operands; it passes them through unchanged.

Reset
REQ-031 rset SHALL force, on the next edge, including mid-job:
- state = IDLE, pointer = 0;
- ack, err, busy, mul_ready = 0;
- result and operand registers = 0;
- mul_rset = 1 for that cycle.
REQ-032 After reset, no ack SHALL be issued for an interrupted job.

Structure
REQ-033 A shared package fpdp_pkg SHALL hold:
- state encodings;
- the QNAN constant;
- N_REQ and the default TIMEOUT.
REQ-034 One sub-module, rr_pick4, SHALL be combinational: given req[3:0] and pointer[1:0], it returns the grant index and a valid flag.
REQ-035 fpdp_multiplication is instantiated by the parent, not inside this block.

Verification
REQ-036 Single request: req = 4'b0001, a = 0x3FEE000000000000 (0.9375), b = 0x3FEA000000000000 (0.8125).
- Required: mul_ready = 0001 for 1 cycle; ack = 0001 with result 0x3FE8600000000000; err = 0.
REQ-037 All four requests asserted together from reset.
- Required: acks in order 0001, 0010, 0100, 1000.
- Required: requester 0 re-asserting after its ack is served after 1000.
REQ-038 Pointer at 2, req = 4'b0011: grant 0 before 1 (wrap-around).
REQ-039 Multiplier model never returns done.
- Required: ack after exactly 3 + TIMEOUT cycles, result = 0x7FF8000000000000, err = 1, mul_rset pulsed.
REQ-040 rset asserted during WAIT.
- Required: next cycle busy = 0, mul_ready = 0; no ack follows.
- Required: a subsequent request is served normally.
REQ-041 Wrong-tag mul_done (0100 while grant = 0): ignored; the correct tag later completes the job.

Source files
------------

// File: rtl/fpdp_pkg.sv
// Shared definitions for the double-precision multiplier arbiter:
// FSM state encoding, the quiet-NaN returned on timeout, requester count,
// default timeout and a one-hot tag helper.
package fpdp_pkg;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned CNT_W       = 8;

  localparam logic [DATA_W-1:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Requester index -> one-hot tag as used on mul_ready/mul_done/ack.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/fpdp_mul_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters.
// Ports:
//   req    : request levels
//   ptr    : round-robin pointer (first index considered)
//   idx_c  : granted index, first set bit at or after ptr, wrapping 3->0
//   vld_c  : high when any request is set
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx_c,
  output logic       vld_c
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    idx_c = 2'd0;
    vld_c = 1'b0;
    cand  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx_c = cand;
        vld_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpdp_mul_arbiter.sv
// Round-robin arbiter sharing one fpdp_multiplication unit among four
// requesters. A job is granted in IDLE, issued for one cycle with a one-hot
// tag, waited on until the multiplier echoes the tag (or a timeout aborts it
// with a qNaN result and a multiplier reset), then acknowledged for one cycle.
// Ports:
//   clk, rset                 : clock, synchronous active-high reset
//   req, req_a, req_b         : per-requester request level and operands
//   ack, result, err, busy    : one-hot completion, product, timeout flag, busy
//   mul_multiplier/_multiplicand, mul_ready, mul_rset : to the multiplier
//   mul_done, mul_product     : from the multiplier
module fpdp_mul_arbiter
  import fpdp_pkg::*;
#(
  parameter int unsigned N_REQ   = fpdp_pkg::N_REQ,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       result,
  output logic                    err,
  output logic                    busy,
  output logic [DATA_W-1:0]       mul_multiplier,
  output logic [DATA_W-1:0]       mul_multiplicand,
  output logic [N_REQ-1:0]        mul_ready,
  output logic                    mul_rset,
  input  logic [N_REQ-1:0]        mul_done,
  input  logic [DATA_W-1:0]       mul_product
);

  localparam logic [CNT_W:0] TO_LIM = TIMEOUT[CNT_W:0];

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx_c (pick_idx),
    .vld_c (pick_vld)
  );

  // One extra bit so TIMEOUT = 255 compares without wrap.
  assign cnt_nxt = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

  // Arbiter FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rset) begin
      state            <= IDLE;
      ptr              <= '0;
      grant            <= '0;
      cnt              <= '0;
      ack              <= '0;
      err              <= 1'b0;
      busy             <= 1'b0;
      result           <= '0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      mul_ready        <= '0;
      mul_rset         <= 1'b1;
    end else begin
      // Pulsed outputs default low every cycle.
      ack       <= '0;
      err       <= 1'b0;
      mul_ready <= '0;
      mul_rset  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant            <= pick_idx;
            mul_multiplier   <= req_a[{pick_idx, 6'd0} +: DATA_W];
            mul_multiplicand <= req_b[{pick_idx, 6'd0} +: DATA_W];
            mul_ready        <= onehot(pick_idx);
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Only the tag of the current grant completes the job.
          if (mul_done == onehot(grant)) begin
            result <= mul_product;
            ack    <= onehot(grant);
            state  <= RESP;
          end else if (cnt_nxt == TO_LIM) begin
            result   <= QNAN;
            err      <= 1'b1;
            ack      <= onehot(grant);
            mul_rset <= 1'b1;
            state    <= RESP;
          end else begin
            cnt <= cnt_nxt[CNT_W-1:0];
          end
        end
        RESP: begin
          ptr   <= grant + IDX_W'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpdp_mul_arbiter.sv
// Self-checking bench for fpdp_mul_arbiter: directed scenarios plus a random
// phase, all checked against a transaction-level round-robin model and a
// behavioural multiplier that computes products with real arithmetic.
// Latency is counted inclusively from the IDLE cycle that sees req through
// the ack cycle.
module tb_fpdp_mul_arbiter;

  localparam int unsigned TO = 20;
  localparam logic [63:0] QNAN_EXP = 64'h7FF8_0000_0000_0000;

  logic         clk = 1'b0;
  logic         rset;
  logic [3:0]   req;
  logic [255:0] req_a, req_b;
  logic [3:0]   ack;
  logic [63:0]  result;
  logic         err, busy;
  logic [63:0]  mul_multiplier, mul_multiplicand;
  logic [3:0]   mul_ready;
  logic         mul_rset;
  logic [3:0]   mul_done;
  logic [63:0]  mul_product;

  always #5 clk = ~clk;

  fpdp_mul_arbiter #(.N_REQ(4), .TIMEOUT(TO)) dut (
    .clk              (clk),
    .rset             (rset),
    .req              (req),
    .req_a            (req_a),
    .req_b            (req_b),
    .ack              (ack),
    .result           (result),
    .err              (err),
    .busy             (busy),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_ready        (mul_ready),
    .mul_rset         (mul_rset),
    .mul_done         (mul_done),
    .mul_product      (mul_product)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model / bookkeeping state
  logic [63:0] op_a [4];
  logic [63:0] op_b [4];
  logic [3:0]  outstanding;
  int          waits [4];
  int          cyc, m_ptr, m_grant, issue_cyc, last_ack_cyc;
  int          acks_q[$];
  logic [63:0] last_res;
  logic        last_err;
  int          ready_pulses, rset_pulses;
  int          lat_start, exp_lat;
  // multiplier model
  logic        job_on;
  logic [3:0]  job_tag;
  logic [63:0] job_prod;
  int          job_done_cyc;
  // scenario knobs
  logic never_done, wrong_tag, rand_on, drop_rand, spurious;
  int   fixed_lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int g);
    if (g < 0) return 4'b0000;
    return 4'b0001 << g;
  endfunction

  // Round-robin rule: first set request at or after the pointer, modulo 4.
  function automatic int rr_expect(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [63:0] rnd_dbl();
    logic [63:0] v;
    v[63]    = 1'($urandom_range(0, 1));
    v[62:52] = 11'(900 + $urandom_range(0, 250));
    v[51:20] = $urandom;
    v[19:0]  = 20'($urandom);
    return v;
  endfunction

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  task automatic raise(input int i, input logic [63:0] a, input logic [63:0] b);
    op_a[i] = a;
    op_b[i] = b;
    req[i] = 1'b1;
    outstanding[i] = 1'b1;
    waits[i] = 0;
    req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
  endtask

  // One cycle: observe at the falling edge, then drive multiplier and requesters.
  task automatic tick();
    int g;
    logic fire;
    @(negedge clk);
    cyc++;
    if (mul_rset) begin
      job_on = 1'b0;
      rset_pulses++;
    end
    if (mul_ready != 4'b0000) begin
      g = rr_expect(req, m_ptr);
      ready_pulses++;
      chk("grant", 64'(mul_ready), 64'(oh(g)));
      chk("ready_once", 64'(m_grant < 0), 64'd1);
      if (last_ack_cyc >= 0) chk("regrant_gap", 64'(cyc - last_ack_cyc >= 2), 64'd1);
      if (g >= 0) begin
        chk("op_a", mul_multiplier, op_a[g]);
        chk("op_b", mul_multiplicand, op_b[g]);
        if (drop_rand && $urandom_range(0, 1) == 1) req[g] = 1'b0;
      end
      m_grant      = g;
      issue_cyc    = cyc;
      job_on       = 1'b1;
      job_tag      = mul_ready;
      job_prod     = fmul(mul_multiplier, mul_multiplicand);
      job_done_cyc = cyc + ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 8)));
    end
    if (ack != 4'b0000) begin
      g = m_grant;
      chk("ack", 64'(ack), 64'(oh(g)));
      if (g >= 0) begin
        chk("result", result, never_done ? QNAN_EXP : fmul(op_a[g], op_b[g]));
        chk("err", 64'(err), 64'(never_done));
        if (never_done) chk("timeout_mul_rset", 64'(mul_rset), 64'd1);
        if (lat_start >= 0) begin
          chk("latency", 64'(cyc - lat_start + 1), 64'(exp_lat));
          lat_start = -1;
        end
        chk("wait_bound", 64'(waits[g] <= 3), 64'd1);
        for (int i = 0; i < 4; i++) if (i != g && outstanding[i]) waits[i]++;
        waits[g] = 0;
        outstanding[g] = 1'b0;
        req[g] = 1'b0;
        m_ptr = (g + 1) % 4;
      end
      last_res = result;
      last_err = err;
      acks_q.push_back(g);
      m_grant = -1;
      last_ack_cyc = cyc;
    end else if (err) begin
      chk("err_without_ack", 64'(err), 64'd0);
    end
    // multiplier model
    fire = job_on && !never_done && (cyc == job_done_cyc);
    mul_done = 4'b0000;
    mul_product = {$urandom, $urandom};
    if (job_on && wrong_tag && cyc == issue_cyc + 1) mul_done = {job_tag[1:0], job_tag[3:2]};
    if (!job_on && spurious && $urandom_range(0, 3) == 0) mul_done = oh(int'($urandom_range(0, 3)));
    if (fire) begin
      mul_done = job_tag;
      mul_product = job_prod;
      job_on = 1'b0;
    end
    // random requesters
    if (rand_on)
      for (int i = 0; i < 4; i++)
        if (!outstanding[i] && $urandom_range(0, 3) == 0) raise(i, rnd_dbl(), rnd_dbl());
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (acks_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    if (acks_q.size() < target) chk("ack_wait", 64'(acks_q.size()), 64'(target));
  endtask

  task automatic do_reset();
    rset = 1'b1;
    req = 4'b0000;
    outstanding = 4'b0000;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    m_ptr = 0;
    m_grant = -1;
    last_ack_cyc = -1;
    tick();
    rset = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved, r0, p0, n, reraised;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    rset = 1'b1;
    req = 4'b0000;
    req_a = '0;
    req_b = '0;
    mul_done = 4'b0000;
    mul_product = '0;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      waits[i] = 0;
    end
    outstanding = 4'b0000;
    cyc = 0; m_ptr = 0; m_grant = -1; issue_cyc = 0; last_ack_cyc = -1;
    last_res = '0; last_err = 1'b0; ready_pulses = 0; rset_pulses = 0;
    lat_start = -1; exp_lat = 0;
    job_on = 1'b0; job_tag = 4'b0000; job_prod = '0; job_done_cyc = 0;
    never_done = 1'b0; wrong_tag = 1'b0; rand_on = 1'b0; drop_rand = 1'b0; spurious = 1'b0;
    fixed_lat = 3;

    // reset state
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_ready", 64'(mul_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_operand", mul_multiplier, 64'd0);
    chk("rst_mul_rset", 64'(mul_rset), 64'd1);
    rset = 1'b0;
    tick();

    // single request, known product
    acks_q.delete();
    fixed_lat = 4;
    r0 = ready_pulses;
    raise(0, 64'h3FEE_0000_0000_0000, 64'h3FEA_0000_0000_0000);
    lat_start = cyc;
    exp_lat = 3 + 4;
    wait_acks(1, 40);
    tick();
    chk("single_result", last_res, 64'h3FE8_6000_0000_0000);
    chk("single_err", 64'(last_err), 64'd0);
    chk("single_ready_cycles", 64'(ready_pulses - r0), 64'd1);
    chk("single_busy_after", 64'(busy), 64'd0);

    // all four at once from reset, requester 0 re-requests after its ack
    do_reset();
    acks_q.delete();
    fixed_lat = 2;
    for (int i = 0; i < 4; i++) raise(i, rnd_dbl(), rnd_dbl());
    reraised = 0;
    n = 0;
    while (acks_q.size() < 5 && n < 200) begin
      tick();
      n++;
      if (reraised == 0 && acks_q.size() >= 1) begin
        raise(0, rnd_dbl(), rnd_dbl());
        reraised = 1;
      end
    end
    chk("rr_count", 64'(acks_q.size()), 64'd5);
    for (int k = 0; k < acks_q.size() && k < 5; k++)
      chk($sformatf("rr_order%0d", k), 64'(acks_q[k]), 64'(exp_order[k]));

    // pointer at 2, requests 0 and 1 -> wrap to 0 first
    do_reset();
    acks_q.delete();
    raise(1, rnd_dbl(), rnd_dbl());
    wait_acks(1, 40);
    raise(0, rnd_dbl(), rnd_dbl());
    raise(1, rnd_dbl(), rnd_dbl());
    wait_acks(3, 80);
    if (acks_q.size() >= 3) begin
      chk("wrap_first", 64'(acks_q[1]), 64'd0);
      chk("wrap_second", 64'(acks_q[2]), 64'd1);
    end

    // multiplier never answers -> timeout abort
    do_reset();
    acks_q.delete();
    never_done = 1'b1;
    p0 = rset_pulses;
    raise(3, rnd_dbl(), rnd_dbl());
    lat_start = cyc;
    exp_lat = 3 + TO;
    wait_acks(1, TO + 30);
    tick();
    tick();
    chk("timeout_result", last_res, QNAN_EXP);
    chk("timeout_err", 64'(last_err), 64'd1);
    chk("timeout_rset_pulses", 64'(rset_pulses - p0), 64'd1);
    never_done = 1'b0;

    // wrong tag first, correct tag later
    acks_q.delete();
    wrong_tag = 1'b1;
    fixed_lat = 5;
    raise(0, rnd_dbl(), rnd_dbl());
    lat_start = cyc;
    exp_lat = 3 + 5;
    wait_acks(1, 40);
    wrong_tag = 1'b0;
    if (acks_q.size() >= 1) chk("wrongtag_ack", 64'(acks_q[0]), 64'd0);

    // reset during WAIT: job dropped, later request still served
    acks_q.delete();
    fixed_lat = 30;
    raise(0, rnd_dbl(), rnd_dbl());
    n = 0;
    while (m_grant < 0 && n < 10) begin
      tick();
      n++;
    end
    chk("midjob_issued", 64'(m_grant), 64'd0);
    repeat (3) tick();
    saved = acks_q.size();
    rset = 1'b1;
    req = 4'b0000;
    outstanding = 4'b0000;
    m_ptr = 0;
    m_grant = -1;
    last_ack_cyc = -1;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(mul_ready), 64'd0);
    chk("midrst_mul_rset", 64'(mul_rset), 64'd1);
    rset = 1'b0;
    repeat (40) tick();
    chk("midrst_no_ack", 64'(acks_q.size()), 64'(saved));
    fixed_lat = 3;
    raise(2, rnd_dbl(), rnd_dbl());
    wait_acks(saved + 1, 30);
    if (acks_q.size() > saved) chk("midrst_next_served", 64'(acks_q[$]), 64'd2);

    // random traffic: random latencies, early req drops, stray done tags
    do_reset();
    acks_q.delete();
    fixed_lat = 0;
    rand_on = 1'b1;
    drop_rand = 1'b1;
    spurious = 1'b1;
    repeat (1500) tick();
    rand_on = 1'b0;
    n = 0;
    while (outstanding != 4'b0000 && n < 300) begin
      tick();
      n++;
    end
    chk("rand_drained", 64'(outstanding), 64'd0);
    chk("rand_enough_jobs", 64'(acks_q.size() > 50), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
